// File: rtl/oled_pkg.sv
// Shared opcode and FSM state encodings for the OLED command arbiter and its helpers.
package oled_pkg;

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_CHAR  = 2'b01;
  localparam logic [1:0] OP_BMP   = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_LOW  = 2'd2,
    S_WAIT_HIGH = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above i_ptr, wrapping modulo NREQ.
module rr_arbiter #(
  parameter int NREQ  = 3,
  parameter int PTR_W = 3
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [NREQ-1:0]  o_gnt,
  output logic [PTR_W-1:0] o_idx,
  output logic             o_valid
);

  int w_pos;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_pos   = 0;
    for (int i = 0; i < NREQ; i++) begin
      w_pos = (int'(i_ptr) + i) % NREQ;
      if (!o_valid && i_req[w_pos]) begin
        o_valid       = 1'b1;
        o_gnt[w_pos]  = 1'b1;
        o_idx         = PTR_W'(w_pos);
      end
    end
  end

endmodule

// File: rtl/oled_cmd_arbiter.sv
// Shares one oledDriver among NREQ requesters: round-robin grant, one-cycle strobe, ready tracking.
// Define OLED_ARB_FIXED_PRIO_EN for static priority (requester 0 highest) instead of round-robin.
module oled_cmd_arbiter
  import oled_pkg::*;
#(
  parameter int NREQ        = 3,
  parameter int ACK_TIMEOUT = 64,
  parameter int PTR_W       = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] op,
  input  logic [8*NREQ-1:0] req_charval,
  input  logic [2*NREQ-1:0] req_row,
  input  logic [4*NREQ-1:0] req_col,
  input  logic [2*NREQ-1:0] req_bmp,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  input  logic              ready,
  output logic              clear,
  output logic              showchar,
  output logic              showbmp,
  output logic [7:0]        charval,
  output logic [1:0]        char_row,
  output logic [3:0]        char_col,
  output logic [1:0]        bmp
);

  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [NREQ-1:0]  ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  state_t            r_state;
  state_t            w_next;
  logic [PTR_W-1:0]  w_ptr;
  logic [NREQ-1:0]   w_arb_gnt;
  logic [PTR_W-1:0]  w_arb_idx;
  logic              w_arb_vld;
  logic              w_grant;
  logic              w_last;
  logic [NREQ-1:0]   w_onehot;

  logic [PTR_W-1:0]  r_idx;
  logic [1:0]        r_op;
  logic [7:0]        r_charval;
  logic [1:0]        r_row;
  logic [3:0]        r_col;
  logic [1:0]        r_bmp;
  logic [CNT_W-1:0]  r_cnt;

`ifdef OLED_ARB_FIXED_PRIO_EN
  assign w_ptr = '0;
`else
  logic [PTR_W-1:0]  r_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_grant) begin
      r_ptr <= (w_arb_idx == PTR_W'(NREQ - 1)) ? '0 : w_arb_idx + 1'b1;
    end
  end

  assign w_ptr = r_ptr;
`endif

  rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .i_req   (req),
    .i_ptr   (w_ptr),
    .o_gnt   (w_arb_gnt),
    .o_idx   (w_arb_idx),
    .o_valid (w_arb_vld)
  );

  assign w_grant  = (r_state == S_IDLE) && ready && w_arb_vld;
  assign w_last   = (r_cnt == CNT_LAST);
  assign w_onehot = ONE_HOT0 << r_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (w_grant) w_next = S_ISSUE;
      S_ISSUE:     w_next = (r_op == OP_RSVD) ? S_IDLE : S_WAIT_LOW;
      S_WAIT_LOW: begin
        if (!ready)      w_next = S_WAIT_HIGH;
        else if (w_last) w_next = S_IDLE;
      end
      S_WAIT_HIGH: if (ready) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // Gnt is gated by rst_n so a live request cannot leak through while reset is held.
  always_comb begin
    gnt      = '0;
    done     = '0;
    clear    = 1'b0;
    showchar = 1'b0;
    showbmp  = 1'b0;
    case (r_state)
      S_IDLE:      if (w_grant && rst_n) gnt = w_arb_gnt;
      S_ISSUE: begin
        case (r_op)
          OP_CLEAR: clear    = 1'b1;
          OP_CHAR:  showchar = 1'b1;
          OP_BMP:   showbmp  = 1'b1;
          default:  done     = w_onehot;
        endcase
      end
      S_WAIT_LOW:  if (ready && w_last) done = w_onehot;
      S_WAIT_HIGH: if (ready) done = w_onehot;
      default:     ;
    endcase
  end

  assign busy = (r_state != S_IDLE);

  // Command latch: captured on grant, held for the driver until the next grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx     <= '0;
      r_op      <= OP_CLEAR;
      r_charval <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_bmp     <= '0;
    end else if (w_grant) begin
      r_idx     <= w_arb_idx;
      r_op      <= op[w_arb_idx*2 +: 2];
      r_charval <= req_charval[w_arb_idx*8 +: 8];
      r_row     <= req_row[w_arb_idx*2 +: 2];
      r_col     <= req_col[w_arb_idx*4 +: 4];
      r_bmp     <= req_bmp[w_arb_idx*2 +: 2];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_state == S_ISSUE) begin
      r_cnt <= '0;
    end else if ((r_state == S_WAIT_LOW) && ready && !w_last) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign charval  = r_charval;
  assign char_row = r_row;
  assign char_col = r_col;
  assign bmp      = r_bmp;

endmodule

// File: tb/tb_oled_cmd_arbiter.sv
// Directed bench for oled_cmd_arbiter: reset, single char, round-robin, timeout, ready gating, reserved op, mid-op reset.
module tb_oled_cmd_arbiter;

  localparam int NREQ = 3;
  localparam int ACK_TIMEOUT = 64;
  localparam int PTR_W = 3;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [2*NREQ-1:0] op;
  logic [8*NREQ-1:0] req_charval;
  logic [2*NREQ-1:0] req_row;
  logic [4*NREQ-1:0] req_col;
  logic [2*NREQ-1:0] req_bmp;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic              busy;
  logic              ready;
  logic              clear;
  logic              showchar;
  logic              showbmp;
  logic [7:0]        charval;
  logic [1:0]        char_row;
  logic [3:0]        char_col;
  logic [1:0]        bmp;

  int checks = 0;
  int errors = 0;

  oled_cmd_arbiter #(
    .NREQ        (NREQ),
    .ACK_TIMEOUT (ACK_TIMEOUT),
    .PTR_W       (PTR_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .op          (op),
    .req_charval (req_charval),
    .req_row     (req_row),
    .req_col     (req_col),
    .req_bmp     (req_bmp),
    .gnt         (gnt),
    .done        (done),
    .busy        (busy),
    .ready       (ready),
    .clear       (clear),
    .showchar    (showchar),
    .showbmp     (showbmp),
    .charval     (charval),
    .char_row    (char_row),
    .char_col    (char_col),
    .bmp         (bmp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change just after the falling edge; outputs are sampled 1 ns later.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    next_cycle();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 3'b111; ready = 1'b1;
    op = '0; req_charval = 24'hFFFFFF; req_row = '1; req_col = '1; req_bmp = '1;
    #1;
    checks++;
    if ({gnt, done, busy, clear, showchar, showbmp} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl got gnt=%b done=%b busy=%b strobes=%b%b%b exp all 0",
               gnt, done, busy, clear, showchar, showbmp);
    end
    checks++;
    if ({charval, char_row, char_col, bmp} !== 16'h0) begin
      errors++;
      $display("FAIL reset_data got %h %h %h %h exp 0", charval, char_row, char_col, bmp);
    end
    next_cycle();
    req = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_single_char();
    next_cycle();
    req = 3'b001; op = 6'b00_00_01; ready = 1'b1;
    req_charval[7:0] = 8'h41; req_row[1:0] = 2'd1; req_col[3:0] = 4'd5;
    #1;
    checks++;
    if (gnt !== 3'b001) begin errors++; $display("FAIL single_gnt got %b exp 001", gnt); end
    next_cycle();
    req = '0;
    #1;
    checks++;
    if ({clear, showchar, showbmp} !== 3'b010 || busy !== 1'b1) begin
      errors++; $display("FAIL single_strobe got c/s/b=%b%b%b busy=%b exp 010 busy 1",
                         clear, showchar, showbmp, busy);
    end
    checks++;
    if (charval !== 8'h41 || char_row !== 2'd1 || char_col !== 4'd5) begin
      errors++; $display("FAIL single_data got %h/%0d/%0d exp 41/1/5", charval, char_row, char_col);
    end
    next_cycle();
    #1;
    checks++;
    if (showchar !== 1'b0 || done !== 3'b000) begin
      errors++; $display("FAIL single_wl got showchar=%b done=%b exp 0 000", showchar, done);
    end
    next_cycle();
    ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      next_cycle();
      #1;
      checks++;
      if (done !== 3'b000 || busy !== 1'b1) begin
        errors++; $display("FAIL single_wh%0d got done=%b busy=%b exp 000 1", k, done, busy);
      end
    end
    next_cycle();
    ready = 1'b1;
    #1;
    checks++;
    if (done !== 3'b001) begin errors++; $display("FAIL single_done got %b exp 001", done); end
    next_cycle();
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 3'b000 || charval !== 8'h41) begin
      errors++; $display("FAIL single_idle got busy=%b done=%b charval=%h exp 0 000 41",
                         busy, done, charval);
    end
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] exp_g;
    do_reset();
    next_cycle();
    op = 6'b01_01_01; req = 3'b111; ready = 1'b1;
    req_charval = 24'h43_42_41;
    for (int n = 0; n < 6; n++) begin
`ifdef OLED_ARB_FIXED_PRIO_EN
      exp_g = 3'b001;
`else
      exp_g = 3'b001 << (n % 3);
`endif
      #1;
      checks++;
      if (gnt !== exp_g) begin errors++; $display("FAIL rr_gnt%0d got %b exp %b", n, gnt, exp_g); end
      next_cycle();
      #1;
      checks++;
      if (showchar !== 1'b1 || gnt !== 3'b000) begin
        errors++; $display("FAIL rr_issue%0d got showchar=%b gnt=%b exp 1 000", n, showchar, gnt);
      end
      next_cycle();
      ready = 1'b0;
      #1;
      checks++;
      if (done !== 3'b000) begin errors++; $display("FAIL rr_wl%0d got done=%b exp 000", n, done); end
      next_cycle();
      ready = 1'b1;
      #1;
      checks++;
      if (done !== exp_g || gnt !== 3'b000) begin
        errors++; $display("FAIL rr_done%0d got done=%b gnt=%b exp %b 000", n, done, gnt, exp_g);
      end
      next_cycle();
    end
    req = '0;
  endtask

  task automatic test_timeout();
    logic [NREQ-1:0] exp_d;
    do_reset();
    next_cycle();
    req = 3'b100; op = 6'b10_00_00; req_bmp = 6'b10_00_00; ready = 1'b1;
    #1;
    checks++;
    if (gnt !== 3'b100) begin errors++; $display("FAIL to_gnt got %b exp 100", gnt); end
    next_cycle();
    req = '0;
    #1;
    checks++;
    if ({clear, showchar, showbmp} !== 3'b001 || bmp !== 2'd2) begin
      errors++; $display("FAIL to_issue got c/s/b=%b%b%b bmp=%0d exp 001 2",
                         clear, showchar, showbmp, bmp);
    end
    for (int k = 0; k < ACK_TIMEOUT; k++) begin
      next_cycle();
      #1;
      exp_d = (k == ACK_TIMEOUT - 1) ? 3'b100 : 3'b000;
      checks++;
      if (done !== exp_d || showbmp !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL to_wl%0d got done=%b showbmp=%b busy=%b exp %b 0 1",
                           k, done, showbmp, busy, exp_d);
      end
    end
    next_cycle();
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 3'b000) begin
      errors++; $display("FAIL to_idle got busy=%b done=%b exp 0 000", busy, done);
    end
  endtask

  task automatic test_ready_low_idle();
    next_cycle();
    req = 3'b010; op = 6'b00_00_00; ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      checks++;
      if (gnt !== 3'b000 || busy !== 1'b0) begin
        errors++; $display("FAIL rl_hold%0d got gnt=%b busy=%b exp 000 0", k, gnt, busy);
      end
      next_cycle();
    end
    ready = 1'b1;
    #1;
    checks++;
    if (gnt !== 3'b010) begin errors++; $display("FAIL rl_gnt got %b exp 010", gnt); end
    next_cycle();
    req = '0;
    #1;
    checks++;
    if ({clear, showchar, showbmp} !== 3'b100) begin
      errors++; $display("FAIL rl_clear got c/s/b=%b%b%b exp 100", clear, showchar, showbmp);
    end
    next_cycle();
    ready = 1'b0;
    next_cycle();
    ready = 1'b1;
    #1;
    checks++;
    if (done !== 3'b010) begin errors++; $display("FAIL rl_done got %b exp 010", done); end
    next_cycle();
  endtask

  task automatic test_rsvd_and_reset();
    do_reset();
    next_cycle();
    req = 3'b001; op = 6'b00_00_11; ready = 1'b1;
    #1;
    checks++;
    if (gnt !== 3'b001) begin errors++; $display("FAIL rsvd_gnt got %b exp 001", gnt); end
    next_cycle();
    req = '0;
    #1;
    checks++;
    if ({clear, showchar, showbmp} !== 3'b000 || done !== 3'b001) begin
      errors++; $display("FAIL rsvd_issue got c/s/b=%b%b%b done=%b exp 000 001",
                         clear, showchar, showbmp, done);
    end
    next_cycle();
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 3'b000) begin
      errors++; $display("FAIL rsvd_idle got busy=%b done=%b exp 0 000", busy, done);
    end
    // Char command from requester 0 leaves the pointer at 1, then reset hits in WAIT_HIGH.
    req = 3'b001; op = 6'b00_00_01; req_charval[7:0] = 8'h5A;
    next_cycle();
    req = '0;
    next_cycle();
    ready = 1'b0;
    next_cycle();
    #1;
    checks++;
    if (busy !== 1'b1 || charval !== 8'h5A) begin
      errors++; $display("FAIL mid_wh got busy=%b charval=%h exp 1 5a", busy, charval);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({gnt, done, busy, clear, showchar, showbmp} !== '0 || {charval, char_row, char_col, bmp} !== 16'h0) begin
      errors++; $display("FAIL mid_rst got gnt=%b done=%b busy=%b charval=%h exp all 0",
                         gnt, done, busy, charval);
    end
    ready = 1'b1;
    next_cycle();
    #1;
    checks++;
    if (done !== 3'b000 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_nodone got done=%b busy=%b exp 000 0", done, busy);
    end
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    req = 3'b101;
    #1;
    checks++;
    if (gnt !== 3'b001) begin errors++; $display("FAIL ptr_reset got gnt=%b exp 001", gnt); end
    next_cycle();
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single_char();
    test_round_robin();
    test_timeout();
    test_ready_low_idle();
    test_rsvd_and_reset();
    repeat (4) next_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
